// File: rtl/mod_counter_param.sv
// Modulo-N up/down counter with load, clear, enable and a wrap-or-saturate policy.
// Flags: combinational terminal count, one-cycle limit pulse and a sticky overflow.
module mod_counter_param #(
  parameter int unsigned     WIDTH     = 4,
  parameter longint unsigned MODULUS   = 16,
  parameter bit              SATURATE  = 1'b0,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             set,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  input  logic             up,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  generate
    if (WIDTH < 32'd1 || WIDTH > 32'd32) begin : g_bad_width
      $error("mod_counter_param: WIDTH must be in 1..32");
    end
    if (MODULUS < 64'd2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
      $error("mod_counter_param: MODULUS must be in 2..2**WIDTH");
    end
    if (RESET_VAL >= MODULUS) begin : g_bad_reset_val
      $error("mod_counter_param: RESET_VAL must be below MODULUS");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] RST_VAL  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(32'd1);

  logic             limit_s;
  logic             event_s;
  logic             ovf_next_s;
  logic [WIDTH-1:0] next_out_s;
  logic [WIDTH-1:0] load_val_s;

  // Lookahead: the next enabled edge will hit a count limit.
  always_comb begin
    limit_s = 1'b0;
    if (en) begin
      limit_s = up ? (out == MAX_VAL) : (out == ZERO_VAL);
    end else begin
      limit_s = 1'b0;
    end
  end

  assign tc = limit_s;

  // Next-count selection with clear > set > en priority; only counting raises a limit event.
  always_comb begin
    next_out_s = out;
    event_s    = 1'b0;
    load_val_s = (64'(init) < MODULUS) ? init : MAX_VAL;
    if (clear) begin
      next_out_s = RST_VAL;
    end else if (set) begin
      next_out_s = load_val_s;
    end else if (en) begin
      if (limit_s) begin
        event_s = 1'b1;
        if (SATURATE) begin
          next_out_s = out;
        end else begin
          next_out_s = up ? ZERO_VAL : MAX_VAL;
        end
      end else begin
        next_out_s = up ? (out + ONE_VAL) : (out - ONE_VAL);
      end
    end else begin
      next_out_s = out;
    end
  end

  // Sticky overflow: a limit event on the same edge beats ovf_clr.
  always_comb begin
    ovf_next_s = ovf;
    if (event_s) begin
      ovf_next_s = 1'b1;
    end else if (ovf_clr) begin
      ovf_next_s = 1'b0;
    end else begin
      ovf_next_s = ovf;
    end
  end

  // State register; reset drops any pending limit pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out  <= RST_VAL;
      wrap <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      out  <= next_out_s;
      wrap <= event_s;
      ovf  <= ovf_next_s;
    end
  end

endmodule

// File: tb/tb_mod_counter_param.sv
// Scoreboard bench for mod_counter_param: four instances share stimulus
// (mod-10 wrap, mod-10 saturate with RESET_VAL=2, mod-16 full range, mod-2 one bit).
module tb_mod_counter_param;

  typedef struct packed {
    logic [3:0] out;
    logic       wrap;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset, clear, set, en, up, ovf_clr;
  logic [3:0] init;

  logic [3:0] out_a, out_b, out_c;
  logic [0:0] out_d;
  logic       tc_a, tc_b, tc_c, tc_d;
  logic       wrap_a, wrap_b, wrap_c, wrap_d;
  logic       ovf_a, ovf_b, ovf_c, ovf_d;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mod_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0), .RESET_VAL(0)) dut_a (
    .clk(clk), .reset(reset), .clear(clear), .set(set), .init(init), .en(en), .up(up),
    .ovf_clr(ovf_clr), .out(out_a), .tc(tc_a), .wrap(wrap_a), .ovf(ovf_a));

  mod_counter_param #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1), .RESET_VAL(2)) dut_b (
    .clk(clk), .reset(reset), .clear(clear), .set(set), .init(init), .en(en), .up(up),
    .ovf_clr(ovf_clr), .out(out_b), .tc(tc_b), .wrap(wrap_b), .ovf(ovf_b));

  mod_counter_param #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0), .RESET_VAL(0)) dut_c (
    .clk(clk), .reset(reset), .clear(clear), .set(set), .init(init), .en(en), .up(up),
    .ovf_clr(ovf_clr), .out(out_c), .tc(tc_c), .wrap(wrap_c), .ovf(ovf_c));

  mod_counter_param #(.WIDTH(1), .MODULUS(2), .SATURATE(1'b0), .RESET_VAL(0)) dut_d (
    .clk(clk), .reset(reset), .clear(clear), .set(set), .init(init[0]), .en(en), .up(up),
    .ovf_clr(ovf_clr), .out(out_d), .tc(tc_d), .wrap(wrap_d), .ovf(ovf_d));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; clear = 1'b0; set = 1'b0; en = 1'b0; up = 1'b1; ovf_clr = 1'b0; init = 4'd0;
    tick();
    tick();
    checks++;
    if ({out_a, wrap_a, ovf_a, tc_a} !== {4'd0, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_a out/wrap/ovf/tc got=%h/%b/%b/%b exp=0/0/0/0", out_a, wrap_a, ovf_a, tc_a);
    end
    checks++;
    if ({out_b, wrap_b, ovf_b} !== {4'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_b out/wrap/ovf got=%h/%b/%b exp=2/0/0", out_b, wrap_b, ovf_b);
    end
    checks++;
    if ({out_c, out_d, wrap_c, wrap_d, ovf_c, ovf_d} !== 9'b0) begin
      failures++;
      $display("FAIL reset_cd out_c/out_d got=%h/%b exp=0/0", out_c, out_d);
    end
    reset = 1'b1;
  endtask

  task automatic test_count_up();
    logic [3:0] seq [12];
    logic [3:0] cur;
    seq = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};
    cur = 4'd0;
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      checks++;
      if (tc_a !== (cur == 4'd9)) begin
        failures++;
        $display("FAIL count_up_tc[%0d] got=%b exp=%b", i, tc_a, (cur == 4'd9));
      end
      sb.push_back('{out: seq[i], wrap: (seq[i] == 4'd0), ovf: (i >= 9)});
      tick();
      e = sb.pop_front();
      checks++;
      if ({out_a, wrap_a, ovf_a} !== e) begin
        failures++;
        $display("FAIL count_up[%0d] out/wrap/ovf got=%h/%b/%b exp=%h/%b/%b",
                 i, out_a, wrap_a, ovf_a, e.out, e.wrap, e.ovf);
      end
      cur = seq[i];
    end
  endtask

  task automatic test_count_down();
    exp_t stim_exp [5];
    stim_exp = '{'{4'd2, 1'b0, 1'b0}, '{4'd0, 1'b0, 1'b0}, '{4'd9, 1'b1, 1'b1},
                 '{4'd9, 1'b0, 1'b1}, '{4'd9, 1'b0, 1'b0}};
    for (int i = 0; i < 5; i++) begin
      en = (i == 2); up = 1'b0; clear = (i == 1);
      ovf_clr = (i == 0) || (i == 2) || (i == 4);
      if (i == 2) begin
        #1;
        checks++;
        if (tc_a !== 1'b1) begin
          failures++;
          $display("FAIL count_down_tc got=%b exp=1", tc_a);
        end
      end
      sb.push_back(stim_exp[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({out_a, wrap_a, ovf_a} !== e) begin
        failures++;
        $display("FAIL count_down[%0d] out/wrap/ovf got=%h/%b/%b exp=%h/%b/%b",
                 i, out_a, wrap_a, ovf_a, e.out, e.wrap, e.ovf);
      end
    end
    clear = 1'b0; ovf_clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_saturate();
    exp_t stim_exp [5];
    stim_exp = '{'{4'd8, 1'b0, 1'b0}, '{4'd9, 1'b0, 1'b0}, '{4'd9, 1'b1, 1'b1},
                 '{4'd9, 1'b1, 1'b1}, '{4'd9, 1'b0, 1'b1}};
    up = 1'b1; init = 4'd8;
    for (int i = 0; i < 5; i++) begin
      set = (i == 0); ovf_clr = (i == 0); en = (i >= 1) && (i <= 3);
      #1;
      checks++;
      if (tc_b !== ((i == 2) || (i == 3))) begin
        failures++;
        $display("FAIL saturate_tc[%0d] got=%b exp=%b", i, tc_b, ((i == 2) || (i == 3)));
      end
      sb.push_back(stim_exp[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({out_b, wrap_b, ovf_b} !== e) begin
        failures++;
        $display("FAIL saturate[%0d] out/wrap/ovf got=%h/%b/%b exp=%h/%b/%b",
                 i, out_b, wrap_b, ovf_b, e.out, e.wrap, e.ovf);
      end
    end
    set = 1'b0; ovf_clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_priority();
    clear = 1'b1; set = 1'b1; init = 4'd5; en = 1'b1; up = 1'b1;
    sb.push_back('{4'd0, 1'b0, 1'b0});
    sb.push_back('{4'd2, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({out_a, wrap_a} !== {e.out, e.wrap}) begin
      failures++;
      $display("FAIL priority_clear_a out/wrap got=%h/%b exp=%h/%b", out_a, wrap_a, e.out, e.wrap);
    end
    e = sb.pop_front();
    checks++;
    if ({out_b, wrap_b} !== {e.out, e.wrap}) begin
      failures++;
      $display("FAIL priority_clear_b out/wrap got=%h/%b exp=%h/%b", out_b, wrap_b, e.out, e.wrap);
    end
    clear = 1'b0; init = 4'd13;
    sb.push_back('{4'd9, 1'b0, 1'b0});
    sb.push_back('{4'd9, 1'b0, 1'b0});
    tick();
    e = sb.pop_front();
    checks++;
    if ({out_a, wrap_a} !== {e.out, e.wrap}) begin
      failures++;
      $display("FAIL priority_clamp_a out/wrap got=%h/%b exp=%h/%b", out_a, wrap_a, e.out, e.wrap);
    end
    e = sb.pop_front();
    checks++;
    if ({out_b, wrap_b} !== {e.out, e.wrap}) begin
      failures++;
      $display("FAIL priority_clamp_b out/wrap got=%h/%b exp=%h/%b", out_b, wrap_b, e.out, e.wrap);
    end
    set = 1'b0; en = 1'b0;
  endtask

  task automatic test_reset_mid_count();
    set = 1'b1; init = 4'd15; en = 1'b0;
    tick();
    set = 1'b0; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sb.push_back('{out: 4'(k - 1), wrap: (k == 1), ovf: 1'b1});
      tick();
      e = sb.pop_front();
      checks++;
      if ({out_c, wrap_c, ovf_c} !== e) begin
        failures++;
        $display("FAIL full_range[%0d] out/wrap/ovf got=%h/%b/%b exp=%h/%b/%b",
                 k, out_c, wrap_c, ovf_c, e.out, e.wrap, e.ovf);
      end
    end
    #3;
    checks++;
    if ({out_b, wrap_b} !== {4'd9, 1'b1}) begin
      failures++;
      $display("FAIL pre_reset_b out/wrap got=%h/%b exp=9/1", out_b, wrap_b);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({out_c, wrap_c, ovf_c} !== {4'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_c out/wrap/ovf got=%h/%b/%b exp=0/0/0", out_c, wrap_c, ovf_c);
    end
    checks++;
    if ({out_b, wrap_b, ovf_b} !== {4'd2, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset_b out/wrap/ovf got=%h/%b/%b exp=2/0/0", out_b, wrap_b, ovf_b);
    end
    #1;
    reset = 1'b1;
    tick();
    checks++;
    if ({out_c, wrap_c, ovf_c} !== {4'd1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL resume_c out/wrap/ovf got=%h/%b/%b exp=1/0/0", out_c, wrap_c, ovf_c);
    end
    checks++;
    if ({out_b, wrap_b} !== {4'd3, 1'b0}) begin
      failures++;
      $display("FAIL resume_b out/wrap got=%h/%b exp=3/0", out_b, wrap_b);
    end
    en = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t stim_exp [5];
    stim_exp = '{'{4'd0, 1'b0, 1'b0}, '{4'd1, 1'b0, 1'b0}, '{4'd0, 1'b1, 1'b1},
                 '{4'd1, 1'b0, 1'b1}, '{4'd0, 1'b1, 1'b1}};
    up = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clear = (i == 0); en = (i != 0);
      sb.push_back(stim_exp[i]);
      tick();
      e = sb.pop_front();
      checks++;
      if ({out_d, wrap_d, ovf_d} !== {e.out[0], e.wrap, e.ovf}) begin
        failures++;
        $display("FAIL back_to_back[%0d] out/wrap/ovf got=%b/%b/%b exp=%b/%b/%b",
                 i, out_d, wrap_d, ovf_d, e.out[0], e.wrap, e.ovf);
      end
    end
    clear = 1'b0; en = 1'b0;
  endtask

  task automatic test_hold();
    set = 1'b1; init = 4'd4; en = 1'b0;
    tick();
    set = 1'b0;
    for (int i = 0; i < 5; i++) begin
      up = i[0];
      #1;
      checks++;
      if (tc_a !== 1'b0) begin
        failures++;
        $display("FAIL hold_tc[%0d] got=%b exp=0", i, tc_a);
      end
      sb.push_back('{4'd4, 1'b0, 1'b0});
      tick();
      e = sb.pop_front();
      checks++;
      if ({out_a, wrap_a} !== {e.out, e.wrap}) begin
        failures++;
        $display("FAIL hold[%0d] out/wrap got=%h/%b exp=%h/%b", i, out_a, wrap_a, e.out, e.wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_count_down();
    test_saturate();
    test_priority();
    test_reset_mid_count();
    test_back_to_back();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
